cnot_gate: RTL and testbench

- Registered Controlled-NOT (Feynman) reversible gate bank, a primitive of the reversible-gate ALU datapath.
- Each lane passes its control bit through unchanged and XORs it into its target bit: y1 = x1, y2 = x1 ^ x2.
- Outputs are registered with a valid strobe.
- A saturating counter records how many accepted operations flipped at least one target bit.

---
 rtl/cnot_gate.sv | 117 +++++++++++
 tb/tb_cnot_gate.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnot_gate.sv
// Registered CNOT (Feynman) gate bank: y1 = x1, y2 = x1 ^ x2 per lane, plus saturating flip-event counter.
// Latency: 1 cycle from in_valid to out_valid; all outputs come straight from flops.
// Backpressure: none; every cycle with in_valid high is accepted, back-to-back ops give back-to-back results.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   sample x1/x2 on this edge
//   x1, x2     control / target bits, WIDTH lanes
//   out_valid  one-cycle strobe, y1/y2 carry a new result
//   y1, y2     registered x1 and x1 ^ x2
//   flip_cnt   saturating count of accepted ops with x1 != 0
//   err        sticky reversibility-check error
//
// Optional build macro CNOT_INV_CHECK_EN: when defined, the accepted inputs are
// kept and each valid result is run back through an inverse CNOT and compared
// against them; any mismatch latches err until reset. Otherwise err is 0.

module cnot_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic             out_valid,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [CNT_W-1:0] flip_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    vld_d = in_valid;
    y1_d  = y1_q;
    y2_d  = y2_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      y1_d = x1;
      y2_d = x1 ^ x2;
      // Only operations with a live control bit actually flip a target.
      if ((|x1) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      y1_q  <= '0;
      y2_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      y1_q  <= y1_d;
      y2_q  <= y2_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign y1        = y1_q;
  assign y2        = y2_q;
  assign flip_cnt  = cnt_q;

`ifdef CNOT_INV_CHECK_EN
  logic [WIDTH-1:0] x1_sav_q, x1_sav_d;
  logic [WIDTH-1:0] x2_sav_q, x2_sav_d;
  logic [WIDTH-1:0] x2_rec;
  logic             err_q, err_d;

  // Inverse CNOT applied to the registered result.
  assign x2_rec = y1_q ^ y2_q;

  always_comb begin
    x1_sav_d = x1_sav_q;
    x2_sav_d = x2_sav_q;
    err_d    = err_q;
    if (in_valid) begin
      x1_sav_d = x1;
      x2_sav_d = x2;
    end
    // The saved copies load on the same edge as y1/y2, so while out_valid is
    // high they describe exactly the operation currently on the outputs.
    if (vld_q && ((x2_rec != x2_sav_q) || (y1_q != x1_sav_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_sav_q <= '0;
      x2_sav_q <= '0;
      err_q    <= 1'b0;
    end else begin
      x1_sav_q <= x1_sav_d;
      x2_sav_q <= x2_sav_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnot_gate.sv
// Self-checking bench for cnot_gate: an 8-lane instance and a 1-lane instance
// with a 2-bit counter share stimulus (the 1-lane one sees lane 0).
// Reference model: per-lane truth-table lookup and saturating integer counters.

module tb_cnot_gate;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] x1, x2;

  logic        ov8, err8;
  logic [7:0]  y1_8, y2_8;
  logic [15:0] cnt8;

  logic        ov1, err1;
  logic [0:0]  y1_1, y2_1;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] m_y1, m_y2;
  logic       m_vld;
  int         m_cnt8, m_cnt1;

  cnot_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x1(x1), .x2(x2),
    .out_valid(ov8), .y1(y1_8), .y2(y2_8), .flip_cnt(cnt8), .err(err8)
  );

  cnot_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x1(x1[0:0]), .x2(x2[0:0]),
    .out_valid(ov1), .y1(y1_1), .y2(y2_1), .flip_cnt(cnt1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-lane reference straight from the truth table.
  function automatic logic [7:0] ref_target(input logic [7:0] c, input logic [7:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({c[i], t[i]})
        2'b00:   r[i] = 1'b0;
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    m_y1 = '0; m_y2 = '0; m_vld = 1'b0; m_cnt8 = 0; m_cnt1 = 0;
  endtask

  // Present inputs, clock once, sample 1 time unit after the edge, update model.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v; x1 = a; x2 = b;
    @(posedge clk); #1;
    m_vld = v;
    if (v) begin
      m_y1 = a;
      m_y2 = ref_target(a, b);
      if (a != 0 && m_cnt8 < 65535) m_cnt8++;
      if (a[0] && m_cnt1 < 3) m_cnt1++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; #1;
    model_clear();
    @(posedge clk); #2;
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    // put something non-zero on the outputs first
    drive(1'b1, 8'hFF, 8'h0F);
    drive(1'b1, 8'h81, 8'h01);
    #2 rst = 1'b1;
    #1; // between edges: reset must act without a clock
    model_clear();
    total++; if (y1_8 !== 8'h00) begin bad++; $display("FAIL reset_y1 got=%h want=00", y1_8); end
    total++; if (y2_8 !== 8'h00) begin bad++; $display("FAIL reset_y2 got=%h want=00", y2_8); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b want=0", ov8); end
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL reset_cnt8 got=%0d want=0", cnt8); end
    total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL reset_cnt1 got=%0d want=0", cnt1); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err8); end
    // reset wins over in_valid on the same edge
    in_valid = 1'b1; x1 = 8'hFF; x2 = 8'h00;
    @(posedge clk); #1;
    total++; if (ov8 !== 1'b0 || y1_8 !== 8'h00) begin bad++; $display("FAIL reset_wins ov=%b y1=%h want 0/00", ov8, y1_8); end
    in_valid = 1'b0;
    #3 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 8'hAA, 8'h55);
      total++;
      if (ov8 !== 0 || y1_8 !== 0 || y2_8 !== 0 || cnt8 !== 0) begin
        bad++; $display("FAIL post_reset_idle ov=%b y1=%h y2=%h cnt=%0d want all 0", ov8, y1_8, y2_8, cnt8);
      end
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] c_in, t_in, c_exp, t_exp;
    c_in = 4'b1100; t_in = 4'b1010;   // entries 00,01,10,11 (index 0 = first)
    c_exp = 4'b1100; t_exp = 4'b0110; // 00,01,11,10
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {7'd0, c_in[3-i]}, {7'd0, t_in[3-i]});
      total++;
      if (ov1 !== 1'b1 || y1_1[0] !== c_exp[3-i] || y2_1[0] !== t_exp[3-i]) begin
        bad++; $display("FAIL truth_%0d ov=%b y1=%b y2=%b want 1/%b/%b", i, ov1, y1_1, y2_1, c_exp[3-i], t_exp[3-i]);
      end
    end
    total++; if (cnt1 !== 2'd2) begin bad++; $display("FAIL truth_cnt got=%0d want=2", cnt1); end
  endtask

  task automatic test_multilane();
    logic [7:0] a, b;
    drive(1'b1, 8'hA5, 8'h3C);
    total++; if (y1_8 !== 8'hA5 || y2_8 !== 8'h99) begin bad++; $display("FAIL multilane y1=%h y2=%h want a5/99", y1_8, y2_8); end
    a = y1_8; b = y2_8;
    drive(1'b1, a, b);
    total++; if (y1_8 !== 8'hA5 || y2_8 !== 8'h3C) begin bad++; $display("FAIL inverse y1=%h y2=%h want a5/3c", y1_8, y2_8); end
  endtask

  task automatic test_idle_hold();
    logic [7:0] h1, h2; int hc;
    drive(1'b1, 8'h5A, 8'hC3);
    h1 = ref_target(8'h5A, 8'hC3) ^ 8'h00; h2 = h1; h1 = 8'h5A;
    hc = m_cnt8;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, $urandom(), $urandom());
      total++;
      if (ov8 !== 1'b0 || y1_8 !== h1 || y2_8 !== h2 || cnt8 !== hc[15:0]) begin
        bad++; $display("FAIL idle_hold_%0d ov=%b y1=%h y2=%h cnt=%0d want 0/%h/%h/%0d", k, ov8, y1_8, y2_8, cnt8, h1, h2, hc);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_seq[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'h01, $urandom());
      total++;
      if (cnt1 !== exp_seq[k][1:0]) begin bad++; $display("FAIL sat_%0d got=%0d want=%0d", k, cnt1, exp_seq[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h00, $urandom());
      total++;
      if (cnt1 !== 2'd3 || cnt8 !== 16'd5) begin bad++; $display("FAIL sat_zero_ctl cnt1=%0d cnt8=%0d want 3/5", cnt1, cnt8); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b; logic v;
    int errs = 0;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
      b = 8'($urandom());
      drive(v, a, b);
      if (ov8 !== m_vld || y1_8 !== m_y1 || y2_8 !== m_y2 || cnt8 !== m_cnt8[15:0] ||
          cnt1 !== m_cnt1[1:0] || ov1 !== m_vld || err8 !== 1'b0 || err1 !== 1'b0) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d ov=%b y1=%h y2=%h cnt8=%0d cnt1=%0d err=%b want %b/%h/%h/%0d/%0d/0",
                   k, ov8, y1_8, y2_8, cnt8, cnt1, err8, m_vld, m_y1, m_y2, m_cnt8, m_cnt1);
      end
    end
    total++; if (errs != 0) bad++;
  endtask

`ifdef CNOT_INV_CHECK_EN
  task automatic test_inv_check();
    drive(1'b1, 8'h0F, 8'hF0);
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL inv_clean got=%b want=0", err8); end
    force dut8.y2_q = 8'h00;
    @(posedge clk); #1;
    release dut8.y2_q;
    total++; if (err8 !== 1'b1) begin bad++; $display("FAIL inv_detect got=%b want=1", err8); end
    for (int k = 0; k < 4; k++) drive(1'b1, $urandom(), $urandom());
    total++; if (err8 !== 1'b1) begin bad++; $display("FAIL inv_sticky got=%b want=1", err8); end
    do_reset();
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL inv_reset got=%b want=0", err8); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0;
    model_clear();
    #12 rst = 1'b0;
    test_reset();
    test_truth_table();
    test_multilane();
    test_idle_hold();
    test_saturation();
    test_random();
`ifdef CNOT_INV_CHECK_EN
    test_inv_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
